// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback merge of ALU and load results onto the
// register-file write port, one FIFO per source, round-robin shared.
//
// Ports:
//   clk, Reset           clock, async active-high reset
//   alu_valid/ready      ALU result handshake, alu_nD/alu_D payload
//   mem_valid/ready      load result handshake, mem_nD/mem_D payload
//   nD, D, RegWE         registered register-file write port
//   busy                 per-register pending-write mask (bit 0 tied 0)

module wb_arbiter_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             in_nd,
  input  logic [DATA_W-1:0]             in_d,
  output logic                          ready,
  output logic                          nempty,
  output logic [ADDR_W-1:0]             hd_nd,
  output logic [DATA_W-1:0]             hd_d,
  output logic [DEPTH-1:0]              vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  nds
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]                  wp;
  logic [PW-1:0]                  rp;
  logic [CW-1:0]                  cnt;
  logic [DEPTH-1:0][ADDR_W-1:0]   mem_nd;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_d;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // ready looks only at the count, so a same-cycle pop never raises it
  assign ready  = (cnt < CW'(DEPTH));
  assign nempty = (cnt != '0);
  assign hd_nd  = mem_nd[rp];
  assign hd_d   = mem_d[rp];
  assign nds    = mem_nd;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        wp      <= nxt(wp);
        vld[wp] <= 1'b1;
      end
      if (pop) begin
        rp      <= nxt(rp);
        vld[rp] <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // payload storage needs no reset; vld qualifies every slot
  always_ff @(posedge clk) begin
    if (push) begin
      mem_nd[wp] <= in_nd;
      mem_d[wp]  <= in_d;
    end
  end

endmodule

module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_nD,
  input  logic [DATA_W-1:0]     alu_D,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_nD,
  input  logic [DATA_W-1:0]     mem_D,
  output logic [ADDR_W-1:0]     nD,
  output logic [DATA_W-1:0]     D,
  output logic                  RegWE,
  output logic [2**ADDR_W-1:0]  busy
);

  logic                         a_ne;
  logic                         m_ne;
  logic [ADDR_W-1:0]            a_hnd;
  logic [ADDR_W-1:0]            m_hnd;
  logic [DATA_W-1:0]            a_hd;
  logic [DATA_W-1:0]            m_hd;
  logic [DEPTH-1:0]             a_vld;
  logic [DEPTH-1:0]             m_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] a_nds;
  logic [DEPTH-1:0][ADDR_W-1:0] m_nds;
  logic                         gnt_a;
  logic                         gnt_m;
  logic                         rr_alu;
  logic [ADDR_W-1:0]            sel_nd;
  logic [DATA_W-1:0]            sel_d;

  wb_arbiter_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_alu_q (
    .clk    (clk),
    .Reset  (Reset),
    .push   (alu_valid && alu_ready),
    .pop    (gnt_a),
    .in_nd  (alu_nD),
    .in_d   (alu_D),
    .ready  (alu_ready),
    .nempty (a_ne),
    .hd_nd  (a_hnd),
    .hd_d   (a_hd),
    .vld    (a_vld),
    .nds    (a_nds)
  );

  wb_arbiter_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_q (
    .clk    (clk),
    .Reset  (Reset),
    .push   (mem_valid && mem_ready),
    .pop    (gnt_m),
    .in_nd  (mem_nD),
    .in_d   (mem_D),
    .ready  (mem_ready),
    .nempty (m_ne),
    .hd_nd  (m_hnd),
    .hd_d   (m_hd),
    .vld    (m_vld),
    .nds    (m_nds)
  );

  // rr_alu=1 means the ALU wins the next contested grant
  always_comb begin
    gnt_a = 1'b0;
    gnt_m = 1'b0;
    unique case (1'b1)
      (a_ne && m_ne): begin
        gnt_a = rr_alu;
        gnt_m = !rr_alu;
      end
      (a_ne && !m_ne): gnt_a = 1'b1;
      (!a_ne && m_ne): gnt_m = 1'b1;
      default: ;
    endcase
  end

  assign sel_nd = gnt_a ? a_hnd : m_hnd;
  assign sel_d  = gnt_a ? a_hd  : m_hd;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rr_alu <= 1'b1;
      RegWE  <= 1'b0;
      nD     <= '0;
      D      <= '0;
    end else if (gnt_a || gnt_m) begin
      rr_alu <= gnt_m;
      nD     <= sel_nd;
      D      <= sel_d;
      // r0 writes still consume a grant but never reach the file
      RegWE  <= (sel_nd != '0);
    end else begin
      RegWE  <= 1'b0;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_vld[i]) busy[a_nds[i]] = 1'b1;
      if (m_vld[i]) busy[m_nds[i]] = 1'b1;
    end
    if (RegWE) busy[nD] = 1'b1;
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a write-order scoreboard
// for the wb_arbiter writeback merge stage.

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_nD;
  logic [15:0] alu_D;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_nD;
  logic [15:0] mem_D;
  logic [3:0]  nD;
  logic [15:0] D;
  logic        RegWE;
  logic [15:0] busy;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W (16),
    .ADDR_W (4),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_nD    (alu_nD),
    .alu_D     (alu_D),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_nD    (mem_nD),
    .mem_D     (mem_D),
    .nD        (nD),
    .D         (D),
    .RegWE     (RegWE),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]  nd;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errs   = 0;
  int   wr_cnt = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [3:0] nd,
                           input logic [15:0] d);
    exp_t x;
    x.nd = nd;
    x.d  = d;
    sb.push_back(x);
  endtask

  // monitor: every presented write is popped and compared
  always @(negedge clk) begin
    if (!Reset) begin
      chk("busy0", {31'b0, busy[0]}, 32'd0);
      if (RegWE) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_write: got nD=%0d D=%h, required none",
                   nD, D);
        end else begin
          e = sb.pop_front();
          chk("wr_nD", {28'b0, nD}, {28'b0, e.nd});
          chk("wr_D", {16'b0, D}, {16'b0, e.d});
        end
      end
    end
  end

  // drive one item; returns #1 after the accepting edge, valid left high
  task automatic push(input bit mem,
                      input logic [3:0] nd,
                      input logic [15:0] d);
    int n = 0;
    bit r;
    if (mem) begin
      mem_valid = 1'b1;
      mem_nD    = nd;
      mem_D     = d;
    end else begin
      alu_valid = 1'b1;
      alu_nD    = nd;
      alu_D     = d;
    end
    do begin
      @(negedge clk);
      r = mem ? mem_ready : alu_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 100);
    if (!r) begin
      checks++;
      errs++;
      $display("FAIL push_timeout: got no accept, required accept of nD=%0d",
               nd);
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    Reset     = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, required end of test");
    $fatal(1);
  end

  initial begin
    int run;
    int n;
    int w0;
    Reset     = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_nD    = '0;
    alu_D     = '0;
    mem_nD    = '0;
    mem_D     = '0;
    #3;
    chk("rst_RegWE", {31'b0, RegWE}, 32'd0);
    chk("rst_nD", {28'b0, nD}, 32'd0);
    chk("rst_D", {16'b0, D}, 32'd0);
    chk("rst_busy", {16'b0, busy}, 32'd0);
    chk("rst_alu_rdy", {31'b0, alu_ready}, 32'd1);
    chk("rst_mem_rdy", {31'b0, mem_ready}, 32'd1);

    // single ALU write, latency and busy window
    do_reset();
    expect_wr(4'd5, 16'h1234);
    push(1'b0, 4'd5, 16'h1234);
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_q", {16'b0, busy}, 32'h0020);
    chk("t1_we_early", {31'b0, RegWE}, 32'd0);
    @(negedge clk);
    chk("t1_we", {31'b0, RegWE}, 32'd1);
    chk("t1_nD", {28'b0, nD}, 32'd5);
    chk("t1_D", {16'b0, D}, 32'h1234);
    chk("t1_busy_wr", {16'b0, busy}, 32'h0020);
    @(negedge clk);
    chk("t1_we_off", {31'b0, RegWE}, 32'd0);
    chk("t1_busy_clr", {16'b0, busy}, 32'd0);
    drain();

    // contention: strict alternation, 8-cycle write burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_wr(4'(i + 1), 16'(16'hA001 + i));
      expect_wr(4'(i + 9), 16'(16'hB009 + i));
    end
    run = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          push(1'b0, 4'(i + 1), 16'(16'hA001 + i));
        alu_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++)
          push(1'b1, 4'(i + 9), 16'(16'hB009 + i));
        mem_valid = 1'b0;
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!RegWE && n < 20);
        while (RegWE && run < 20) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk("t2_burst_len", run, 32'd8);
    drain();

    // backpressure: mem fills after 2 accepts, nothing lost
    do_reset();
    expect_wr(4'd1, 16'hA001);
    expect_wr(4'd9, 16'hB009);
    expect_wr(4'd2, 16'hA002);
    expect_wr(4'd10, 16'hB00A);
    expect_wr(4'd3, 16'hA003);
    expect_wr(4'd11, 16'hB00B);
    expect_wr(4'd4, 16'hA004);
    expect_wr(4'd5, 16'hA005);
    expect_wr(4'd6, 16'hA006);
    fork
      begin
        for (int i = 0; i < 6; i++)
          push(1'b0, 4'(i + 1), 16'(16'hA001 + i));
        alu_valid = 1'b0;
      end
      begin
        push(1'b1, 4'd9, 16'hB009);
        push(1'b1, 4'd10, 16'hB00A);
        chk("t3_mem_full", {31'b0, mem_ready}, 32'd0);
        push(1'b1, 4'd11, 16'hB00B);
        mem_valid = 1'b0;
      end
    join
    drain();

    // register 0 is popped but never written
    do_reset();
    expect_wr(4'd3, 16'h0333);
    push(1'b0, 4'd0, 16'hFFFF);
    chk("t4_busy_r0", {16'b0, busy}, 32'd0);
    push(1'b0, 4'd3, 16'h0333);
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t4_r0_we", {31'b0, RegWE}, 32'd0);
    chk("t4_busy_r3", {16'b0, busy}, 32'h0008);
    @(negedge clk);
    chk("t4_r3_we", {31'b0, RegWE}, 32'd1);
    chk("t4_r3_nD", {28'b0, nD}, 32'd3);
    drain();

    // async reset with entries queued and one write in flight
    do_reset();
    fork
      begin
        push(1'b0, 4'd1, 16'hC001);
        push(1'b0, 4'd2, 16'hC002);
        alu_valid = 1'b0;
      end
      begin
        push(1'b1, 4'd9, 16'hD009);
        push(1'b1, 4'd10, 16'hD00A);
        mem_valid = 1'b0;
      end
    join
    chk("t5_pre_busy", {16'b0, busy}, 32'h0606);
    chk("t5_pre_mrdy", {31'b0, mem_ready}, 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    chk("t5_we", {31'b0, RegWE}, 32'd0);
    chk("t5_busy", {16'b0, busy}, 32'd0);
    chk("t5_alu_rdy", {31'b0, alu_ready}, 32'd1);
    chk("t5_mem_rdy", {31'b0, mem_ready}, 32'd1);
    chk("t5_nD", {28'b0, nD}, 32'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    w0 = wr_cnt;
    repeat (12) @(negedge clk);
    chk("t5_no_writes", wr_cnt - w0, 32'd0);

    // wrap: 10 back-to-back ALU pushes
    do_reset();
    for (int i = 0; i < 10; i++)
      expect_wr(4'(i + 1), 16'(16'h1000 + i * 16'h0111));
    for (int i = 0; i < 10; i++)
      push(1'b0, 4'(i + 1), 16'(16'h1000 + i * 16'h0111));
    alu_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage directly upstream of the SP-core register file. It merges results from two producers, the ALU and the load/memory unit, onto the register file's single write port (nD, D, RegWE). Each source has its own small FIFO, and the two sources share the port by round-robin arbitration. A per-register pending-write mask is exported so the issue stage can hold instructions on RAW hazards.

Parameters:
DATA_W, 16, data width; matches register file D.
ADDR_W, 4, register index width; the register file has 2**ADDR_W registers.
DEPTH, 2, entries per source FIFO; any value >=1, pointers wrap at DEPTH.

Ports:
clk  input  1  core clock; all state updates on posedge.
Reset  input  1  asynchronous, active-high reset.
alu_valid  input  1  ALU result offered.
alu_ready  output  1  ALU FIFO can accept.
alu_nD  input  ADDR_W  ALU destination register.
alu_D  input  DATA_W  ALU result.
mem_valid  input  1  load result offered.
mem_ready  output  1  memory FIFO can accept.
mem_nD  input  ADDR_W  load destination register.
mem_D  input  DATA_W  load data.
nD  output  ADDR_W  to register file write-port index.
D  output  DATA_W  to register file write data.
RegWE  output  1  to register file write enable.
busy  output  2**ADDR_W  bit r=1 while a write to r is pending.

Behaviour:
- Reset, asynchronous on assertion:
  - both FIFOs emptied (counts 0, pointers 0);
  - RegWE=0, nD=0, D=0;
  - round-robin pointer set so ALU wins the first contested grant;
  - busy=0.
- Reset mid-operation discards all queued and in-flight results; no write is issued after release for them.
- Enqueue: a transfer occurs on a posedge with src_valid && src_ready.
  - src_ready = (count_src < DEPTH), combinational from count only.
  - A same-cycle pop does not raise ready.
  - valid with ready=0: no transfer; the source holds its data stable.
- Arbitration, evaluated every cycle on the FIFO heads:
  - neither FIFO non-empty: no grant;
  - exactly one non-empty: that one is granted;
  - both non-empty: grant the source not granted last time, then update the pointer;
  - the pointer updates only on a grant.
- Grant: the granted head is popped at the posedge, and the output register loads nD<=head.nD, D<=head.D, RegWE<=(head.nD!=0).
- Writes to register 0 are popped and count as a grant for round-robin, but are dropped (RegWE=0).
- No grant: RegWE<=0; nD and D hold their previous values.
- Latency: accept at edge k into an empty FIFO with no contention gives grant during cycle k+1, RegWE=1 after edge k+1, and the register file write at edge k+2.
- Throughput: one write per cycle sustained.
- Simultaneous push and pop on the same FIFO: both take effect; count is unchanged and pointers advance with wrap at DEPTH.
- Ordering:
  - Per-source FIFO order is preserved.
  - Cross-source order equals grant order.
  - Same-destination conflicts across sources are the issue stage's responsibility, enforced via busy.
- busy[r] is combinational from state. It is 1 if any valid entry in either FIFO has nD==r, or if RegWE==1 and nD==r.
  - busy[0] is always 0.
  - busy clears in the cycle after the write is presented, i.e. once RegWE drops or nD changes.
- No overflow is possible. Underflow cannot occur: a pop happens only on a grant to a non-empty FIFO.

Test Plan:
- Single ALU write: alu_valid=1 for 1 cycle with nD=5, D=0x1234 -> RegWE=1, nD=5, D=0x1234 exactly 2 edges after accept; busy[5]=1 from accept until RegWE drops; all else 0.
- Contention: both sources push each cycle for 4 cycles (ALU nD=1..4, mem nD=9..12) -> write order 1,9,2,10,3,11,4,12; RegWE high 8 consecutive cycles.
- Full/backpressure: DEPTH=2, hold mem_valid=1 with the ALU stream saturating -> mem_ready=0 after 2 accepts; no data lost or duplicated; held data accepted once ready returns.
- Register 0 drop: ALU push nD=0, D=0xFFFF, then nD=3 -> no RegWE for r0; RegWE for r3 one cycle later; busy[0] never set.
- Reset mid-flight: queue 2 ALU and 2 mem entries, assert Reset asynchronously between edges -> RegWE/busy/ready go 0/0/1 immediately; no writes after release.
- FIFO wrap: 10 back-to-back ALU pushes with no mem traffic -> 10 writes in order, D values intact across pointer wrap.
